// File: rtl/note_recorder.sv
// note_recorder
// Records keypad note codes as run-length-encoded entries {note, run} on each
// beat_tick, then replays them one entry at a time as a 4-bit code stream for
// the tone player. The replay stream is one input of the player source mux.
//
// Ports:
//   ext_clk_25m  in   system clock (25 MHz)
//   ext_rst_n    in   asynchronous active-low reset
//   beat_tick    in   one-cycle sample/playback strobe (>= 4 clocks apart)
//   note_code    in   live keypad note code, 0 = rest
//   start_rec    in   pulse: begin recording
//   start_play   in   pulse: begin replay
//   stop         in   pulse: end recording or replay
//   loop_en      in   level: replay wraps to entry 0 instead of finishing
//   play_code    out  replayed note code, 0 when not playing
//   rec_len      out  number of valid buffer entries
//   recording    out  high while recording
//   playing      out  high while loading or playing an entry
//   rec_full     out  last recording ended because the buffer filled
//   play_done    out  one-cycle pulse at the non-looped end of replay
module note_recorder #(
    parameter int ADDR_W = 8,
    parameter int RUN_W  = 6
) (
    input  logic              ext_clk_25m,
    input  logic              ext_rst_n,
    input  logic              beat_tick,
    input  logic [3:0]        note_code,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              stop,
    input  logic              loop_en,
    output logic [3:0]        play_code,
    output logic [ADDR_W:0]   rec_len,
    output logic              recording,
    output logic              playing,
    output logic              rec_full,
    output logic              play_done
);

    localparam int                ENTRY_W = 4 + RUN_W;
    localparam logic [RUN_W-1:0]  MAX_RUN = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0]  ONE_RUN = RUN_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_LOAD, S_PLAY} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ENTRY_W-1:0]  r_mem [0:(1 << ADDR_W)-1];
    logic [ENTRY_W-1:0]  r_rd_data;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [3:0]          r_cur_note;
    logic [RUN_W-1:0]    r_run_cnt;
    logic                r_run_valid;
    logic [RUN_W-1:0]    r_remain;
    logic [3:0]          r_play_code;
    logic [ADDR_W:0]     r_rec_len;
    logic                r_rec_full;
    logic                r_play_done;

    // Event decode shared by the FSM and the datapath
    logic w_rec_start, w_play_start, w_rec_stop, w_rec_tick;
    logic w_rec_first, w_rec_extend, w_rec_wr_tick, w_rec_fill, w_mem_we;
    logic w_play_stop, w_play_tick, w_run_end, w_has_next;
    logic w_advance, w_wrap, w_finish;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;

    assign w_rec_start   = (r_state == S_IDLE) && start_rec;
    assign w_play_start  = (r_state == S_IDLE) && !start_rec && start_play
                           && (r_rec_len != '0);
    assign w_rec_stop    = (r_state == S_RECORD) && stop;
    // stop takes priority: a tick arriving with stop is never sampled
    assign w_rec_tick    = (r_state == S_RECORD) && !stop && beat_tick;
    assign w_rec_first   = w_rec_tick && !r_run_valid;
    assign w_rec_extend  = w_rec_tick && r_run_valid && (note_code == r_cur_note)
                           && (r_run_cnt != MAX_RUN);
    assign w_rec_wr_tick = w_rec_tick && r_run_valid && !w_rec_extend;
    // Writing the last slot fills the buffer; the note that forced it is dropped
    assign w_rec_fill    = w_rec_wr_tick && (&r_wr_ptr);
    assign w_mem_we      = w_rec_wr_tick || (w_rec_stop && r_run_valid);

    assign w_play_stop   = ((r_state == S_LOAD) || (r_state == S_PLAY)) && stop;
    assign w_play_tick   = (r_state == S_PLAY) && !stop && beat_tick;
    assign w_run_end     = w_play_tick && (r_remain == ONE_RUN);
    assign w_has_next    = ({1'b0, r_rd_ptr} + (ADDR_W+1)'(1)) < r_rec_len;
    assign w_advance     = w_run_end && w_has_next;
    assign w_wrap        = w_run_end && !w_has_next && loop_en;
    assign w_finish      = w_run_end && !w_has_next && !loop_en;

    // The buffer read is registered, so it is addressed with the pointer value
    // that LOAD will see; the entry is then valid during the LOAD cycle.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_play_start || w_wrap)
            w_rd_ptr_nxt = '0;
        else if (w_advance)
            w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
    end

    // State register
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rec_start)
                    w_state_nxt = S_RECORD;
                else if (w_play_start)
                    w_state_nxt = S_LOAD;
            end
            S_RECORD: begin
                if (w_rec_stop || w_rec_fill)
                    w_state_nxt = S_IDLE;
            end
            S_LOAD: begin
                w_state_nxt = stop ? S_IDLE : S_PLAY;
            end
            S_PLAY: begin
                if (w_play_stop || w_finish)
                    w_state_nxt = S_IDLE;
                else if (w_advance || w_wrap)
                    w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        recording = (r_state == S_RECORD);
        playing   = (r_state == S_LOAD) || (r_state == S_PLAY);
    end

    assign play_code = r_play_code;
    assign rec_len   = r_rec_len;
    assign rec_full  = r_rec_full;
    assign play_done = r_play_done;

    // Record/replay datapath
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cur_note  <= '0;
            r_run_cnt   <= '0;
            r_run_valid <= 1'b0;
            r_remain    <= '0;
            r_play_code <= '0;
            r_rec_len   <= '0;
            r_rec_full  <= 1'b0;
            r_play_done <= 1'b0;
        end else begin
            if (w_rec_start) begin
                r_wr_ptr    <= '0;
                r_run_valid <= 1'b0;
                r_rec_full  <= 1'b0;
            end

            if (w_rec_first) begin
                r_cur_note  <= note_code;
                r_run_cnt   <= ONE_RUN;
                r_run_valid <= 1'b1;
            end else if (w_rec_extend) begin
                r_run_cnt   <= r_run_cnt + ONE_RUN;
            end else if (w_rec_wr_tick) begin
                r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                r_cur_note  <= note_code;
                r_run_cnt   <= ONE_RUN;
            end

            if (w_rec_fill) begin
                r_rec_len  <= DEPTH_L;
                r_rec_full <= 1'b1;
            end else if (w_rec_stop) begin
                r_rec_len  <= {1'b0, r_wr_ptr} + {{ADDR_W{1'b0}}, r_run_valid};
            end

            r_rd_ptr    <= w_rd_ptr_nxt;
            r_play_done <= w_finish;

            if ((r_state == S_LOAD) && !stop) begin
                r_play_code <= r_rd_data[ENTRY_W-1 -: 4];
                r_remain    <= r_rd_data[RUN_W-1:0];
            end else if (w_play_stop || w_finish) begin
                r_play_code <= '0;
            end else if (w_play_tick && (r_remain > ONE_RUN)) begin
                r_remain    <= r_remain - ONE_RUN;
            end
        end
    end

    // Entry buffer: synchronous write, registered read, contents never reset
    always_ff @(posedge ext_clk_25m) begin
        if (w_mem_we)
            r_mem[r_wr_ptr] <= {r_cur_note, r_run_cnt};
        r_rd_data <= r_mem[w_rd_ptr_nxt];
    end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model that
// keeps the raw tick samples of a recording and run-length encodes them.
module tb_note_recorder;

    localparam int AW    = 4;
    localparam int RW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int MAXR  = (1 << RW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_REC  = 1;
    localparam int M_LOAD = 2;
    localparam int M_PLAY = 3;

    logic          clk;
    logic          rst_n;
    logic          beat_tick;
    logic [3:0]    note_code;
    logic          start_rec;
    logic          start_play;
    logic          stop;
    logic          loop_en;
    logic [3:0]    play_code;
    logic [AW:0]   rec_len;
    logic          recording;
    logic          playing;
    logic          rec_full;
    logic          play_done;

    note_recorder #(.ADDR_W(AW), .RUN_W(RW)) dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst_n),
        .beat_tick   (beat_tick),
        .note_code   (note_code),
        .start_rec   (start_rec),
        .start_play  (start_play),
        .stop        (stop),
        .loop_en     (loop_en),
        .play_code   (play_code),
        .rec_len     (rec_len),
        .recording   (recording),
        .playing     (playing),
        .rec_full    (rec_full),
        .play_done   (play_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int smp[$];           // raw notes sampled during the current recording
    int bn[$];            // stored entries: note
    int br[$];            // stored entries: run length
    int m_mode = M_IDLE;
    int m_code = 0;
    int m_len  = 0;
    int m_full = 0;
    int m_done = 0;
    int m_idx  = 0;
    int m_rem  = 0;

    task automatic build();
        bn.delete();
        br.delete();
        foreach (smp[i]) begin
            if (bn.size() != 0 && bn[bn.size()-1] == smp[i] && br[br.size()-1] < MAXR)
                br[br.size()-1] = br[br.size()-1] + 1;
            else begin
                bn.push_back(smp[i]);
                br.push_back(1);
            end
        end
    endtask

    task automatic model_step();
        m_done = 0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_code = 0; m_len = 0; m_full = 0;
            m_idx = 0; m_rem = 0; smp.delete();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (start_rec) begin
                    m_mode = M_REC; smp.delete(); m_full = 0;
                end else if (start_play && m_len != 0) begin
                    m_mode = M_LOAD; m_idx = 0;
                end
            end
            M_REC: begin
                if (stop) begin
                    build(); m_len = bn.size(); m_mode = M_IDLE;
                end else if (beat_tick) begin
                    smp.push_back(int'(note_code));
                    build();
                    if (bn.size() > DEPTH) begin
                        void'(smp.pop_back());
                        build();
                        m_len = DEPTH; m_full = 1; m_mode = M_IDLE;
                    end
                end
            end
            M_LOAD: begin
                if (stop) begin
                    m_code = 0; m_mode = M_IDLE;
                end else begin
                    m_code = bn[m_idx]; m_rem = br[m_idx]; m_mode = M_PLAY;
                end
            end
            default: begin
                if (stop) begin
                    m_code = 0; m_mode = M_IDLE;
                end else if (beat_tick) begin
                    if (m_rem > 1) m_rem = m_rem - 1;
                    else if (m_idx + 1 < m_len) begin m_idx = m_idx + 1; m_mode = M_LOAD; end
                    else if (loop_en) begin m_idx = 0; m_mode = M_LOAD; end
                    else begin m_code = 0; m_done = 1; m_mode = M_IDLE; end
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("play_code", int'(play_code), m_code);
            chk("recording", int'(recording), int'(m_mode == M_REC));
            chk("playing",   int'(playing),   int'(m_mode == M_LOAD || m_mode == M_PLAY));
            chk("rec_full",  int'(rec_full),  m_full);
            chk("play_done", int'(play_done), m_done);
            chk("rec_len",   int'(rec_len),   m_len);
            if (play_done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic t, input logic [3:0] n, input logic sr,
                       input logic sp, input logic st);
        @(negedge clk);
        beat_tick = t; note_code = n; start_rec = sr; start_play = sp; stop = st;
    endtask

    task automatic idle(input int k);
        repeat (k) drv(1'b0, note_code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick(input logic [3:0] n);
        drv(1'b1, n, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic ptick(output int c);
        drv(1'b1, note_code, 1'b0, 1'b0, 1'b0);
        c = int'(play_code);
        idle(3);
    endtask

    int c;
    int d0;
    int hold;
    int since;

    initial begin
        rst_n = 1'b0; beat_tick = 1'b0; note_code = 4'd0;
        start_rec = 1'b0; start_play = 1'b0; stop = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_play_code", int'(play_code), 0);
        chk("reset_rec_len", int'(rec_len), 0);

        // start_play with an empty buffer stays idle
        drv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("empty_play_ignored", int'(playing), 0);

        // Basic record/replay: 5,5,5,0,0
        drv(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick(4'd5); tick(4'd5); tick(4'd5); tick(4'd0); tick(4'd0);
        drv(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("basic_rec_len", int'(rec_len), 2);
        d0 = done_cnt;
        drv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        ptick(c); chk("basic_t0", c, 5);
        ptick(c); chk("basic_t1", c, 5);
        ptick(c); chk("basic_t2", c, 5);
        ptick(c); chk("basic_t3", c, 0);
        ptick(c); chk("basic_t4", c, 0);
        chk("basic_done_once", done_cnt - d0, 1);
        chk("basic_playing_low", int'(playing), 0);

        // Run saturation: 70 ticks of note 7 -> {7,63},{7,7}
        drv(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (70) tick(4'd7);
        drv(1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("sat_rec_len", int'(rec_len), 2);
        d0 = done_cnt;
        drv(1'b0, 4'd0, 1'b1 & 1'b0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 70; i++) begin
            ptick(c);
            if (c != 7) chk("sat_replay_note", c, 7);
        end
        chk("sat_done_once", done_cnt - d0, 1);

        // Overflow: distinct notes until the buffer fills
        drv(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) tick(4'((i % 15) + 1));
        chk("ovf_full", int'(rec_full), 1);
        chk("ovf_len", int'(rec_len), DEPTH);
        chk("ovf_not_recording", int'(recording), 0);
        drv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) begin
            ptick(c);
            chk("ovf_replay", c, (i % 15) + 1);
        end

        // Looping replay of {3,1},{9,2}, then stop
        drv(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick(4'd3); tick(4'd9); tick(4'd9);
        drv(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        loop_en = 1'b1;
        d0 = done_cnt;
        drv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 9; i++) begin
            ptick(c);
            chk("loop_seq", c, (i % 3 == 0) ? 3 : 9);
        end
        chk("loop_no_done", done_cnt - d0, 0);
        drv(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("loop_stop_code", int'(play_code), 0);
        chk("loop_stop_playing", int'(playing), 0);
        loop_en = 1'b0;

        // Arbitration: start_rec beats start_play; stop beats a same-cycle tick
        drv(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("arb_recording", int'(recording), 1);
        tick(4'd4); tick(4'd4);
        drv(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("stop_tick_len", int'(rec_len), 1);
        chk("stop_tick_full", int'(rec_full), 0);

        // Reset in the middle of replay
        drv(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick(4'd8); tick(4'd8); tick(4'd2);
        drv(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        ptick(c); chk("pre_reset_code", c, 8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_play_code", int'(play_code), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_rec_len", int'(rec_len), 0);
        chk("rst_recording", int'(recording), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drv(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("post_rst_play_ignored", int'(playing), 0);

        // Randomized phase
        hold = 0;
        since = 10;
        for (int cy = 0; cy < 12000; cy++) begin
            @(negedge clk);
            beat_tick = (since >= 3) && ($urandom_range(0, 3) == 0);
            since = beat_tick ? 0 : since + 1;
            if (hold == 0) begin
                note_code = 4'($urandom_range(0, 15));
                hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 400))
                                                   : int'($urandom_range(0, 12));
            end else begin
                hold--;
            end
            start_rec  = ($urandom_range(0, 79) == 0);
            start_play = ($urandom_range(0, 29) == 0);
            stop       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
        end
        loop_en = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Captures the 4-bit note codes produced by the keypad scanner into an internal run-length-encoded buffer, then replays them as a 4-bit audio code stream for the tone player.
- It is the writer/reader counterpart to the fixed-ROM music fetcher: the player input mux selects either the ROM stream or this block's replay stream.
- Timing is driven by an external one-cycle beat_tick strobe.

Parameters:
- ADDR_W, 8, buffer address width; DEPTH = 2^ADDR_W entries.
- RUN_W, 6, run-length field width; MAX_RUN = 2^RUN_W - 1.

Ports:
- ext_clk_25m  in  1  system clock, 25 MHz.
- ext_rst_n  in  1  asynchronous active-low reset.
- beat_tick  in  1  one-cycle sample/playback strobe; consecutive strobes are at least 4 clocks apart.
- note_code  in  4  live keypad note code; 0 = rest.
- start_rec  in  1  pulse: begin recording.
- start_play  in  1  pulse: begin replay.
- stop  in  1  pulse: end recording or replay.
- loop_en  in  1  level: replay wraps to entry 0 instead of finishing.
- play_code  out  4  replayed note code; 0 when not playing.
- rec_len  out  ADDR_W+1  number of valid entries stored.
- recording  out  1  high in RECORD.
- playing  out  1  high in LOAD or PLAY.
- rec_full  out  1  last recording ended because the buffer filled.
- play_done  out  1  one-cycle pulse at non-looped end of replay.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; pointers and counters 0. Buffer contents are not cleared; they are unreachable because rec_len=0.
- Buffer entry format: {note[3:0], run[RUN_W-1:0]}, with run in 1..MAX_RUN. The array uses registered (1-cycle) read.
- States: IDLE, RECORD, LOAD, PLAY.
- IDLE:
  - start_rec → RECORD; wr_ptr=0, run_valid=0, rec_full=0.
  - Else start_play with rec_len≠0 → LOAD; rd_ptr=0.
  - start_play with rec_len=0 is ignored.
  - start_rec and start_play in the same cycle: start_rec wins.
  - stop is ignored.
- RECORD, on beat_tick (stop not asserted):
  - run_valid=0: cur_note=note_code, run_cnt=1, run_valid=1.
  - note_code==cur_note and run_cnt<MAX_RUN: run_cnt+1.
  - Otherwise: write {cur_note,run_cnt} to mem[wr_ptr], wr_ptr+1, then cur_note=note_code, run_cnt=1.
  - If that write used slot DEPTH-1: the newly sampled note is discarded, rec_len=DEPTH, rec_full=1, → IDLE.
- RECORD, on stop:
  - If run_valid, flush the pending run to mem[wr_ptr]; rec_len=wr_ptr+1.
  - Else rec_len=wr_ptr.
  - → IDLE. A beat_tick in the same cycle as stop is ignored.
  - start_rec and start_play are ignored while in RECORD.
- LOAD (exactly 1 cycle): play_code=mem[rd_ptr].note, remain=mem[rd_ptr].run, → PLAY.
  - play_code therefore changes 2 clocks after start_play or after the entry-advancing tick.
- PLAY, on beat_tick:
  - remain>1: remain-1.
  - remain==1 and rd_ptr+1<rec_len: rd_ptr+1, → LOAD.
  - remain==1 and rd_ptr+1==rec_len:
    - loop_en=1: rd_ptr=0, → LOAD.
    - loop_en=0: play_code=0, play_done=1 for one cycle, → IDLE.
- Stop in LOAD or PLAY: play_code=0 on the next clock, → IDLE, no play_done. start_rec and start_play are ignored while playing.
- rec_len and rec_full hold their values until the next start_rec. Replay never modifies the buffer.
- Widths: run_cnt and remain are RUN_W bits and never wrap. Saturation forces a new entry with the same note.

Test Plan:
1. Record: note 5 for 3 ticks, note 0 for 2 ticks, then stop → rec_len=2, entries {5,3},{0,2}. Play → play_code=5 for 3 ticks, then 0 for 2 ticks; play_done pulses once; playing falls.
2. Run saturation (RUN_W=6): note 7 held for 70 ticks, then stop → rec_len=2, entries {7,63},{7,7}. Replay gives note 7 for 70 ticks.
3. Overflow (ADDR_W=2): notes 1,2,3,4,5,6 at one tick each → after the 4th write rec_full=1, rec_len=4, recording=0. Replay gives 1,2,3,4.
4. Looping: loop_en=1 with 2 stored entries → sequence repeats with no play_done. A stop pulse gives play_code=0 one clock later and playing=0.
5. Arbitration: start_play with rec_len=0 → stays IDLE. start_rec and start_play in the same cycle → recording=1. Stop in the same cycle as beat_tick during RECORD → only the pending run is flushed.
6. Reset mid-PLAY: assert ext_rst_n=0 → all outputs 0 immediately and rec_len=0. A subsequent start_play is ignored.
